// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcode values,
// {N,Z,C,V} flag bit positions, FSM state encoding and payload structs.
package alu_op_sequencer_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned TIMER_W = 8;

  // ALU selector codes; 4'b1111 has no operation and is forwarded as-is.
  localparam logic [OP_W-1:0] OP_ADD     = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB     = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL     = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV     = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND     = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR      = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR     = 4'b0110;
  localparam logic [OP_W-1:0] OP_NOT     = 4'b0111;
  localparam logic [OP_W-1:0] OP_SHL     = 4'b1000;
  localparam logic [OP_W-1:0] OP_SHR     = 4'b1001;
  localparam logic [OP_W-1:0] OP_ROL     = 4'b1010;
  localparam logic [OP_W-1:0] OP_ROR     = 4'b1011;
  localparam logic [OP_W-1:0] OP_CMP     = 4'b1100;
  localparam logic [OP_W-1:0] OP_MOV     = 4'b1101;
  localparam logic [OP_W-1:0] OP_TST     = 4'b1110;
  localparam logic [OP_W-1:0] OP_INVALID = 4'b1111;

  // Bit positions inside the 4-bit flag vector {N,Z,C,V}.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic              timeout;
  } alu_rsp_t;

endpackage

// File: rtl/alu_op_sequencer_wait_timer.sv
// Wait-cycle counter for the sequencer.
// Ports: clk, rst (sync, active-high), clear_i (zero the count),
// enable_i (count one cycle), limit_i (abort threshold),
// expired_c_o (combinational: the next increment reaches limit_i).
module alu_wait_timer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = TIMER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_c_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear has priority over counting.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Looks one increment ahead so the abort lands in the cycle the count hits the limit.
  assign expired_c_o = ((count_q + CNT_W'(1)) == limit_i);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one request at a time onto a multi-cycle ALU: operand A with a
// start strobe, then operand B, waits for finish (or aborts after TIMEOUT
// wait cycles) and holds the captured result until downstream takes it.
// Ports: clk, rst (sync, active-high);
//   request  : req_valid/req_ready, req_op, req_a, req_b
//   ALU side : alu_start, alu_s, alu_inbus, alu_outbus, alu_finish, alu_flags
//   response : rsp_valid/rsp_ready, rsp_result, rsp_flags, rsp_timeout
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_s,
  output logic [DATA_W-1:0] alu_inbus,
  input  logic [DATA_W-1:0] alu_outbus,
  input  logic              alu_finish,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_timeout
);

  seq_state_e        state_q, state_d;
  alu_req_t          req_q, req_d;
  alu_rsp_t          rsp_q, rsp_d;
  logic              req_ready_q, req_ready_d;
  logic              alu_start_q, alu_start_d;
  logic [OP_W-1:0]   alu_s_q, alu_s_d;
  logic [DATA_W-1:0] alu_inbus_q, alu_inbus_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              tmr_clear;
  logic              tmr_enable;
  logic              tmr_expired;

  alu_wait_timer #(
    .CNT_W (TIMER_W)
  ) u_wait_timer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (tmr_clear),
    .enable_i    (tmr_enable),
    .limit_i     (TIMER_W'(TIMEOUT)),
    .expired_c_o (tmr_expired)
  );

  // Next state plus the output values for the state being entered, so every
  // output comes straight from a flop and lines up with the state it belongs to.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_d       = rsp_q;
    req_ready_d = 1'b0;
    alu_start_d = 1'b0;
    alu_s_d     = '0;
    alu_inbus_d = '0;
    rsp_valid_d = 1'b0;
    tmr_clear   = 1'b0;
    tmr_enable  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d       = '{op: req_op, a: req_a, b: req_b};
          state_d     = ST_SEND_A;
          alu_start_d = 1'b1;
          alu_s_d     = req_op;
          alu_inbus_d = req_a;
        end else begin
          req_ready_d = 1'b1;
        end
      end

      ST_SEND_A: begin
        state_d     = ST_SEND_B;
        alu_s_d     = req_q.op;
        alu_inbus_d = req_q.b;
      end

      ST_SEND_B: begin
        tmr_clear   = 1'b1;
        state_d     = ST_WAIT;
        alu_s_d     = req_q.op;
        alu_inbus_d = req_q.b;
      end

      ST_WAIT: begin
        alu_s_d     = req_q.op;
        alu_inbus_d = req_q.b;
        // Finish is checked first so it wins over a simultaneous expiry.
        if (alu_finish) begin
          rsp_d       = '{result: alu_outbus, flags: alu_flags, timeout: 1'b0};
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          alu_s_d     = '0;
          alu_inbus_d = '0;
        end else begin
          tmr_enable = 1'b1;
          if (tmr_expired) begin
            rsp_d       = '{result: '0, flags: '0, timeout: 1'b1};
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            alu_s_d     = '0;
            alu_inbus_d = '0;
          end
        end
      end

      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      req_ready_q <= 1'b1;
      alu_start_q <= 1'b0;
      alu_s_q     <= '0;
      alu_inbus_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      req_ready_q <= req_ready_d;
      alu_start_q <= alu_start_d;
      alu_s_q     <= alu_s_d;
      alu_inbus_q <= alu_inbus_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign alu_start   = alu_start_q;
  assign alu_s       = alu_s_q;
  assign alu_inbus   = alu_inbus_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_q.result;
  assign rsp_flags   = rsp_q.flags;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes hand-computed
// responses, a monitor pops them on each response handshake, and a simple
// behavioural ALU answers start strobes after a per-request delay.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int unsigned TO = 127;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        alu_start;
  logic [3:0]  alu_s;
  logic [15:0] alu_inbus;
  logic [15:0] alu_outbus;
  logic        alu_finish;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_timeout;

  alu_op_sequencer #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_start   (alu_start),
    .alu_s       (alu_s),
    .alu_inbus   (alu_inbus),
    .alu_outbus  (alu_outbus),
    .alu_finish  (alu_finish),
    .alu_flags   (alu_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_timeout (rsp_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    logic        to;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          dly;   // WAIT cycles before finish; <= 0 means never finish
  } job_t;

  exp_t sb_q[$];
  job_t job_q[$];
  int   acc_q[$];

  int total = 0;
  int bad   = 0;
  int stray_req  = 0;
  int stray_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural ALU: result followed by {N,Z,C,V}.
  function automatic logic [19:0] alu_calc(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [16:0] w;
    logic [31:0] p;
    logic [15:0] r;
    logic [3:0]  f;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[15:0];
        c = w[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_MUL: begin
        p = 32'(a) * 32'(b);
        r = p[15:0];
      end
      OP_AND: r = a & b;
      default: r = '0;
    endcase
    f         = '0;
    f[FLAG_N] = r[15];
    f[FLAG_Z] = (r == 16'd0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return {r, f};
  endfunction

  // ALU responder: checks the operand sequence and raises finish after the job delay.
  job_t        j;
  logic [19:0] r_alu;
  initial begin
    alu_finish = 1'b0;
    alu_outbus = '0;
    alu_flags  = '0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        alu_finish = 1'b1;
        alu_outbus = 16'hBEEF;
        alu_flags  = 4'hF;
        @(negedge clk);
        alu_finish = 1'b0;
        alu_outbus = '0;
        alu_flags  = '0;
      end else if (alu_start === 1'b1 && rst === 1'b0) begin
        chk("alu_job_expected", 32'(job_q.size() != 0), 32'd1);
        if (job_q.size() != 0) begin
          j = job_q.pop_front();
          chk("alu_s_send_a", 32'(alu_s), 32'(j.op));
          chk("alu_inbus_a", 32'(alu_inbus), 32'(j.a));
          @(negedge clk);
          chk("alu_start_one_cycle", 32'(alu_start), 32'd0);
          chk("alu_inbus_b", 32'(alu_inbus), 32'(j.b));
          chk("alu_s_send_b", 32'(alu_s), 32'(j.op));
          if (j.dly > 0) begin
            repeat (j.dly) @(negedge clk);
            chk("alu_inbus_wait", 32'(alu_inbus), 32'(j.b));
            r_alu      = alu_calc(j.op, j.a, j.b);
            alu_finish = 1'b1;
            alu_outbus = r_alu[19:4];
            alu_flags  = r_alu[3:0];
            @(negedge clk);
            alu_finish = 1'b0;
            alu_outbus = '0;
            alu_flags  = '0;
          end
        end
      end
    end
  end

  // Response monitor: latency and idle ALU bus on the first valid cycle, payload on handshake.
  bit   in_rsp = 1'b0;
  exp_t e;
  int   acc_cyc;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        acc_q.delete();
        in_rsp = 1'b0;
      end else begin
        if (req_valid === 1'b1 && req_ready === 1'b1) acc_q.push_back(cyc);
        if (rsp_valid === 1'b1 && !in_rsp) begin
          in_rsp = 1'b1;
          chk("rsp_expected", 32'(sb_q.size() != 0 && acc_q.size() != 0), 32'd1);
          if (sb_q.size() != 0 && acc_q.size() != 0) begin
            e       = sb_q[0];
            acc_cyc = acc_q.pop_front();
            chk("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
            chk("resp_alu_start", 32'(alu_start), 32'd0);
            chk("resp_alu_s", 32'(alu_s), 32'd0);
            chk("resp_alu_inbus", 32'(alu_inbus), 32'd0);
            chk("resp_req_ready", 32'(req_ready), 32'd0);
          end
        end
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
          in_rsp = 1'b0;
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("rsp_result", 32'(rsp_result), 32'(e.res));
            chk("rsp_flags", 32'(rsp_flags), 32'(e.flg));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int dly, input bit expect_rsp, input logic [15:0] er,
                       input logic [3:0] ef, input logic et, input int el);
    int n;
    job_q.push_back('{op: op, a: a, b: b, dly: dly});
    if (expect_rsp) sb_q.push_back('{res: er, flg: ef, to: et, lat: el});
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready !== 1'b1 && n < 300);
    chk("req_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb_q.size() == 0 && req_ready === 1'b1 && rsp_valid === 1'b0) && n < 400);
    chk("drain_done", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_alu_start", 32'(alu_start), 32'd0);
    chk("reset_alu_s", 32'(alu_s), 32'd0);
    chk("reset_alu_inbus", 32'(alu_inbus), 32'd0);
    chk("reset_rsp_result", 32'(rsp_result), 32'd0);
    chk("reset_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(posedge clk);
    #1;

    // op, a, b, finish delay, expect response, result, {N,Z,C,V}, timeout, latency
    issue(OP_ADD, 16'd5, 16'd2147, 1, 1'b1, 16'd2152, 4'b0000, 1'b0, 4);
    drain();
    issue(OP_MUL, 16'd5, 16'd2147, 3, 1'b1, 16'd10735, 4'b0000, 1'b0, 6);
    drain();
    issue(OP_SUB, 16'd3, 16'd5, 2, 1'b1, 16'd65534, 4'b1010, 1'b0, 5);
    drain();
    issue(OP_AND, 16'h00F0, 16'h0F00, 1, 1'b1, 16'd0, 4'b0100, 1'b0, 4);
    drain();
    // ALU never finishes: abort after TIMEOUT wait cycles.
    issue(OP_ADD, 16'd7, 16'd9, 0, 1'b1, 16'd0, 4'b0000, 1'b1, 130);
    drain();
    // Finish lands in the same cycle the timer expires: data wins.
    issue(OP_ADD, 16'd100, 16'd200, 127, 1'b1, 16'd300, 4'b0000, 1'b0, 130);
    drain();
    // Undefined opcode passes through and is resolved by timeout.
    issue(OP_INVALID, 16'd1, 16'd2, 0, 1'b1, 16'd0, 4'b0000, 1'b1, 130);
    drain();

    // Stray finish while idle must not disturb anything.
    stray_req++;
    repeat (4) begin
      @(negedge clk);
      chk("stray_req_ready", 32'(req_ready), 32'd1);
      chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("stray_alu_start", 32'(alu_start), 32'd0);
    end
    @(posedge clk);
    #1;

    // Backpressure: response held, next request blocked until it is taken.
    rsp_ready = 1'b0;
    issue(OP_SUB, 16'd3, 16'd5, 2, 1'b1, 16'd65534, 4'b1010, 1'b0, 5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid !== 1'b1 && n < 50);
    chk("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    job_q.push_back('{op: OP_AND, a: 16'd14, b: 16'd11, dly: 1});
    sb_q.push_back('{res: 16'd10, flg: 4'b0000, to: 1'b0, lat: 4});
    req_op    = OP_AND;
    req_a     = 16'd14;
    req_b     = 16'd11;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", 32'(rsp_result), 32'd65534);
      chk("bp_rsp_flags", 32'(rsp_flags), 32'b1010);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_req_ready_at_take", 32'(req_ready), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready !== 1'b1 && n < 20);
    chk("bp_second_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();

    // Reset in WAIT drops the operation without a response.
    issue(OP_ADD, 16'd1, 16'd2, 0, 1'b0, 16'd0, 4'b0000, 1'b0, 0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("wrst_req_ready", 32'(req_ready), 32'd1);
    chk("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wrst_alu_inbus", 32'(alu_inbus), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("wrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(OP_AND, 16'd14, 16'd11, 1, 1'b1, 16'd10, 4'b0000, 1'b0, 4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    repeat (20000) @(posedge clk);
    total++;
    bad++;
    $display("FAIL watchdog: got no completion want completion within 20000 cycles");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 127, maximum cycles spent waiting for ALU finish before aborting (range 1..255).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  in  1  upstream request present.
REQ-005 Port: req_ready  out  1  sequencer accepts request this cycle.
REQ-006 Port: req_op  in  4  ALU selector code (0000 ADD .. 1110 TST).
REQ-007 Port: req_a  in  16  first operand (shift amount for shift/rotate ops).
REQ-008 Port: req_b  in  16  second operand.
REQ-009 Port: alu_start  out  1  ALU start strobe.
REQ-010 Port: alu_s  out  4  ALU selector.
REQ-011 Port: alu_inbus  out  16  ALU operand bus.
REQ-012 Port: alu_outbus  in  16  ALU result bus.
REQ-013 Port: alu_finish  in  1  ALU completion.
REQ-014 Port: alu_flags  in  4  {negative, zero, carry, overflow} from ALU.
REQ-015 Port: rsp_valid  out  1  response held for downstream.
REQ-016 Port: rsp_ready  in  1  downstream accepts response.
REQ-017 Port: rsp_result  out  16  captured result.
REQ-018 Port: rsp_flags  out  4  captured {N,Z,C,V}.
REQ-019 Port: rsp_timeout  out  1  response is an abort (no finish within TIMEOUT).

Function
REQ-020 FSM states IDLE, SEND_A, SEND_B, WAIT, RESP; one state per cycle except WAIT and RESP.
REQ-021 IDLE: req_ready=1; on req_valid&req_ready, op/a/b registered, go SEND_A.
REQ-022 SEND_A: alu_start=1, alu_s=op, alu_inbus=a for exactly one cycle; go SEND_B.
REQ-023 SEND_B: alu_start=0, alu_s=op, alu_inbus=b for one cycle; timeout counter cleared; go WAIT.
REQ-024 WAIT: alu_s=op, alu_inbus=b held; first cycle alu_finish=1 captures alu_outbus and alu_flags, rsp_timeout=0, go RESP.
REQ-025 WAIT: counter increments each cycle without finish; when counter reaches TIMEOUT, rsp_result=0, rsp_flags=0, rsp_timeout=1, go RESP.
REQ-026 RESP: rsp_valid=1, outputs stable until rsp_valid&rsp_ready; then go IDLE; req_ready=0 in every state other than IDLE.
REQ-027 Latency: request accept to rsp_valid = 3 + N cycles, N = WAIT cycles until finish (N>=1); back-to-back minimum 1 IDLE cycle between responses.
REQ-028 alu_finish outside WAIT is ignored; a finish on the same cycle as timeout reaching TIMEOUT wins (result captured, rsp_timeout=0).
REQ-029 alu_start=0 and alu_s/alu_inbus=0 in IDLE and RESP.
REQ-030 Invalid op 1111 accepted and forwarded unchanged; resolved by timeout if the ALU never finishes.

Reset
REQ-031 rst=1 at a clock edge forces IDLE; req_ready=1 in the following cycle, all other outputs 0, counter 0, captured registers 0.
REQ-032 rst asserted mid-operation (any state) aborts without producing a response; any pending rsp_valid drops the next cycle.

Structure
REQ-033 Shared package holds the 4-bit ALU opcode constants, the flag bit-index constants, and the FSM state encoding.
REQ-034 Timeout counter is a single sub-module alu_wait_timer (clear, enable, limit, expired); everything else in one module.

Verification
REQ-035 ADD a=5 b=2147, ALU finishes after 1 WAIT cycle -> alu_start high exactly 1 cycle with inbus=5, next cycle inbus=2147; rsp_result=2152, flags 0000, rsp_timeout=0, rsp_valid 4 cycles after accept.
REQ-036 MUL a=5 b=2147 against real ALU -> rsp_result=10735, flags N=0 Z=0, response only after alu_finish.
REQ-037 Stub ALU never finishes, TIMEOUT=127 -> rsp_valid with rsp_timeout=1, result 0, 130 cycles after accept.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles -> rsp_result/flags stable, req_ready=0 throughout; new req_valid not accepted until response taken.
REQ-039 rst asserted during WAIT -> no rsp_valid, req_ready=1 next cycle, fresh AND a=14 b=11 then yields rsp_result=10.
REQ-040 Finish coincident with timeout expiry and stray finish in IDLE -> former returns data with rsp_timeout=0, latter causes no state change.
